// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED frame scheduler.
//   rgb_t          : one LED pixel, red in the most significant byte
//   sched_state_e  : scheduler FSM states
//   scale8()       : brightness scaling of one 8-bit colour channel
// Optional feature macro used by the scheduler: LED_BRIGHTNESS_EN
// -----------------------------------------------------------------------------
package led_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ARM  = 2'd2,
    SEND = 2'd3
  } sched_state_e;

  localparam int unsigned PIXEL_W = 24;

  // (c * (b + 1)) >> 8 : b = 255 is the identity, b = 0 gives black.
  // The product is at most 255 * 256, which fits in 16 bits.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/led_frame_pacer.sv
// -----------------------------------------------------------------------------
// led_frame_pacer
// Free-running frame-period counter. Counts 0..PERIOD-1 and wraps; the last
// count is the tick. A tick is remembered until the scheduler launches a
// transfer and asserts clear_tick_i.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear_tick_i   : a transfer launches this cycle, forget the seen tick
//   tick_seen_o    : a tick happened since the last launch (includes the
//                    tick of the current cycle)
// -----------------------------------------------------------------------------
module led_frame_pacer
  import led_pkg::*;
#(
  parameter int unsigned PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_tick_i,
  output logic tick_seen_o
);

  if (PERIOD < 2) begin : g_period_check
    $error("led_frame_pacer: FREQ/FPS must be at least 2");
  end

  localparam int unsigned CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_seen_q, tick_seen_d;
  logic             tick_s;

  assign tick_s      = (count_q == LAST);
  // The current tick counts as seen so a launch can use it immediately.
  assign tick_seen_o = tick_s | tick_seen_q;

  // Next-state for the period counter and the tick latch.
  always_comb begin
    count_d     = count_q;
    tick_seen_d = tick_seen_q;
    if (tick_s) begin
      count_d = {CNT_W{1'b0}};
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    // A launch consumes the tick, including one arriving in the same cycle.
    if (clear_tick_i) begin
      tick_seen_d = 1'b0;
    end else begin
      tick_seen_d = tick_seen_o;
    end
  end

  // Period counter and tick latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= {CNT_W{1'b0}};
      tick_seen_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      tick_seen_q <= tick_seen_d;
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// -----------------------------------------------------------------------------
// led_frame_scheduler
// Buffers one pending full-strip frame (latest wins), paces strip updates to
// FPS and runs the start/done handshake of the WS2801 driver. drv_rgb comes
// from a working buffer that only changes at launch (and during LOAD), so it
// is stable for the whole transfer.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   frame_in/_valid     : frame from the visualizer, LED0 red[7] is the MSB
//   frame_ready         : frame accepted this cycle when valid
//   drv_rgb             : frame presented to the driver
//   drv_start/drv_done  : driver handshake (done high while driver waits)
//   busy                : a transfer is in progress
//   drop_cnt            : saturating count of overwritten pending frames
//   bright_in/bright_we : brightness register write (LED_BRIGHTNESS_EN only)
// Optional feature macro: LED_BRIGHTNESS_EN adds a LOAD state that scales the
// working buffer one LED per cycle by the brightness latched at launch.
// -----------------------------------------------------------------------------
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int unsigned LEDS = 50,
  parameter int unsigned FREQ = 12_500_000,
  parameter int unsigned FPS  = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [24*LEDS-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [24*LEDS-1:0] drv_rgb,
  output logic               drv_start,
  input  logic               drv_done,
  output logic               busy,
  output logic [7:0]         drop_cnt
`ifdef LED_BRIGHTNESS_EN
  ,
  input  logic [7:0]         bright_in,
  input  logic               bright_we
`endif
);

  localparam int unsigned PERIOD = FREQ / FPS;
  localparam int unsigned FW     = PIXEL_W * LEDS;

  sched_state_e  state_q, state_d;
  logic          frame_ready_q;
  logic          pend_q, pend_d;
  logic [FW-1:0] pend_buf_q, pend_buf_d;
  logic [FW-1:0] work_q, work_d;
  logic [7:0]    drop_q, drop_d;
  logic          drv_start_q, drv_start_d;
  logic          busy_q, busy_d;
  logic          accept_s;
  logic          launch_s;
  logic          tick_seen_s;

`ifdef LED_BRIGHTNESS_EN
  localparam int unsigned IDX_W = (LEDS > 2) ? $clog2(LEDS) : 1;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       bright_q;
  logic [7:0]       bright_lat_q;
  rgb_t             px_s;
`endif

  led_frame_pacer #(
    .PERIOD (PERIOD)
  ) u_pacer (
    .clk          (clk),
    .rst          (rst),
    .clear_tick_i (launch_s),
    .tick_seen_o  (tick_seen_s)
  );

  assign accept_s    = frame_valid & frame_ready_q;
  assign frame_ready = frame_ready_q;
  assign drv_rgb     = work_q;
  assign drv_start   = drv_start_q;
  assign busy        = busy_q;
  assign drop_cnt    = drop_q;

  // FSM next state, buffer updates and drop accounting.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_buf_d = pend_buf_q;
    work_d     = work_q;
    drop_d     = drop_q;
    launch_s   = 1'b0;
`ifdef LED_BRIGHTNESS_EN
    idx_d      = idx_q;
    px_s       = '0;
`endif

    case (state_q)
      IDLE: begin
        // drv_done low here means the driver is still finishing an earlier
        // transfer; wait for it while keeping the tick latched.
        if (tick_seen_s && pend_q && drv_done) begin
          launch_s = 1'b1;
          work_d   = pend_buf_q;
`ifdef LED_BRIGHTNESS_EN
          idx_d    = {IDX_W{1'b0}};
          state_d  = LOAD;
`else
          state_d  = ARM;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
`ifdef LED_BRIGHTNESS_EN
        for (int i = 0; i < int'(LEDS); i++) begin
          if (idx_q == IDX_W'(i)) begin
            px_s   = work_q[PIXEL_W*i +: PIXEL_W];
            px_s.r = scale8(px_s.r, bright_lat_q);
            px_s.g = scale8(px_s.g, bright_lat_q);
            px_s.b = scale8(px_s.b, bright_lat_q);
            work_d[PIXEL_W*i +: PIXEL_W] = px_s;
          end else begin
            work_d[PIXEL_W*i +: PIXEL_W] = work_q[PIXEL_W*i +: PIXEL_W];
          end
        end
        if (idx_q == IDX_W'(LEDS - 1)) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = ARM;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
`else
        state_d = ARM;
`endif
      end
      ARM: begin
        // Driver dropping done means it has taken the start request.
        if (!drv_done) begin
          state_d = SEND;
        end else begin
          state_d = ARM;
        end
      end
      SEND: begin
        if (drv_done) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An accept on the launch cycle refills pending without being a drop.
    if (accept_s) begin
      pend_buf_d = frame_in;
      pend_d     = 1'b1;
      if (pend_q && !launch_s && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end else begin
        drop_d = drop_q;
      end
    end else if (launch_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    drv_start_d = (state_d == ARM);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      frame_ready_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_buf_q    <= {FW{1'b0}};
      work_q        <= {FW{1'b0}};
      drop_q        <= 8'd0;
      drv_start_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_ready_q <= 1'b1;
      pend_q        <= pend_d;
      pend_buf_q    <= pend_buf_d;
      work_q        <= work_d;
      drop_q        <= drop_d;
      drv_start_q   <= drv_start_d;
      busy_q        <= busy_d;
    end
  end

`ifdef LED_BRIGHTNESS_EN
  // Brightness register, its launch-time snapshot and the LOAD LED index.
  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q     <= 8'hFF;
      bright_lat_q <= 8'hFF;
      idx_q        <= {IDX_W{1'b0}};
    end else begin
      bright_q     <= bright_we ? bright_in : bright_q;
      bright_lat_q <= launch_s ? bright_q : bright_lat_q;
      idx_q        <= idx_d;
    end
  end
`endif

endmodule
